alu_mdu: RTL and testbench

Parametrised, clocked successor to the single-cycle datapath ALU. It executes the full logic/shift/compare set in one registered cycle, and adds an iterative multiply/divide unit behind a valid/ready handshake. It sits in the EX stage of the multi-cycle processor. The control unit stalls on `in_ready` while a multiply or divide is in flight.

---
 rtl/alu_mdu_pkg.sv | 35 +++
 rtl/alu_mdu_iter.sv | 73 +++++++
 rtl/alu_mdu.sv | 156 +++++++++++++++
 tb/tb_alu_mdu.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: operation codes, FSM states and multi-cycle op classification for alu_mdu.
// The multi-cycle set includes DIV/REM only when ALU_MDU_DIV_EN is defined.
package alu_mdu_pkg;

    localparam logic [4:0] OP_ADD      = 5'd0;
    localparam logic [4:0] OP_SUB      = 5'd1;
    localparam logic [4:0] OP_AND      = 5'd2;
    localparam logic [4:0] OP_OR       = 5'd3;
    localparam logic [4:0] OP_XOR      = 5'd4;
    localparam logic [4:0] OP_NOR      = 5'd5;
    localparam logic [4:0] OP_SLL      = 5'd6;
    localparam logic [4:0] OP_SRL      = 5'd7;
    localparam logic [4:0] OP_SRA      = 5'd8;
    localparam logic [4:0] OP_SLT      = 5'd9;
    localparam logic [4:0] OP_SHL_HALF = 5'd10;
    localparam logic [4:0] OP_MUL      = 5'd11;
    localparam logic [4:0] OP_MULH     = 5'd12;
    localparam logic [4:0] OP_DIV      = 5'd13;
    localparam logic [4:0] OP_REM      = 5'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multi(input logic [4:0] op);
`ifdef ALU_MDU_DIV_EN
        return (op >= OP_MUL) && (op <= OP_REM);
`else
        return (op == OP_MUL) || (op == OP_MULH);
`endif
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: shared iterative datapath, one shift-add (multiply) or restoring-subtract
// (divide) step per cycle on magnitudes. Divide logic exists only with ALU_MDU_DIV_EN.
module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);
    localparam int CW = $clog2(WIDTH);

    // hi: upper product half / partial remainder; lo: multiplier / quotient bits
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   mul_sum;

    assign mul_sum = {1'b0, hi} + ({(WIDTH+1){lo[0]}} & {1'b0, op_b});

`ifdef ALU_MDU_DIV_EN
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // When fits, the difference is below op_b, so the low WIDTH bits are exact
    assign shifted = {hi, lo[WIDTH-1]};
    assign fits    = shifted >= {1'b0, op_b};
    assign diff    = shifted[WIDTH-1:0] - op_b;

    always_comb begin
        next_hi = mul_sum[WIDTH:1];
        next_lo = {mul_sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            next_hi = fits ? diff : shifted[WIDTH-1:0];
            next_lo = {lo[WIDTH-2:0], fits};
        end
    end
`else
    logic unused_div;
    assign unused_div = is_div;
    assign next_hi    = mul_sum[WIDTH:1];
    assign next_lo    = {mul_sum[0], lo[WIDTH-1:1]};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            op_b  <= '0;
        end else if (start) begin
            count <= '0;
            hi    <= '0;
            lo    <= a;
            op_b  <= b;
        end else if (step) begin
            count <= count + 1'b1;
            hi    <= next_hi;
            lo    <= next_lo;
        end
    end

    assign last = step && (count == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered single-cycle ALU plus iterative multiply/divide behind valid/ready.
// Define ALU_MDU_DIV_EN to build the divider; otherwise DIV/REM finish in one cycle with out=0.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHAMT_LSB = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUCtrl,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             div_by_zero,
    output state_t           state
);
    // Handshake: a request transfers on a rising edge where in_valid && in_ready; in_valid is
    // ignored otherwise. out_valid is a one-cycle pulse with no back-pressure on the result side.
    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]      shamt;
    logic               lt;
    logic [WIDTH-1:0]   sc_result;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               start;
    logic               step;
    logic               last;
    logic [WIDTH-1:0]   next_hi;
    logic [WIDTH-1:0]   next_lo;
    logic [4:0]         op_q;
    logic               neg_q;
    logic               neg_rem_q;
    logic               dbz_q;
    logic               is_div_q;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   mc_result;

    assign shamt = in2[SHAMT_LSB +: SW];
    assign lt    = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

    always_comb begin
        sc_result = '0;
        case (ALUCtrl)
            OP_ADD:      sc_result = in1 + in2;
            OP_SUB:      sc_result = in1 - in2;
            OP_AND:      sc_result = in1 & in2;
            OP_OR:       sc_result = in1 | in2;
            OP_XOR:      sc_result = in1 ^ in2;
            OP_NOR:      sc_result = ~(in1 | in2);
            OP_SLL:      sc_result = in1 << shamt;
            OP_SRL:      sc_result = in1 >> shamt;
            OP_SRA:      sc_result = $signed(in1) >>> shamt;
            OP_SLT:      sc_result = {{(WIDTH-1){1'b0}}, lt};
            OP_SHL_HALF: sc_result = in1 << (WIDTH / 2);
            default:     sc_result = '0;
        endcase
    end

    // The iterative unit works on magnitudes; signs are reapplied when the result is written
    assign sign_a = Sign & in1[WIDTH-1];
    assign sign_b = Sign & in2[WIDTH-1];
    assign a_mag  = sign_a ? -in1 : in1;
    assign b_mag  = sign_b ? -in2 : in2;

    assign start    = (state == IDLE) && in_valid && is_multi(ALUCtrl);
    assign step     = (state == BUSY);
    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_REM);

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .step    (step),
        .is_div  (is_div_q),
        .a       (a_mag),
        .b       (b_mag),
        .last    (last),
        .next_hi (next_hi),
        .next_lo (next_lo)
    );

    assign prod     = {next_hi, next_lo};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        mc_result = '0;
        case (op_q)
            OP_MUL:  mc_result = prod_fix[WIDTH-1:0];
            OP_MULH: mc_result = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV:  mc_result = dbz_q ? '1 : (neg_q ? -next_lo : next_lo);
            default: mc_result = neg_rem_q ? -next_hi : next_hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out         <= '0;
            div_by_zero <= 1'b0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_multi(ALUCtrl)) begin
                            state     <= BUSY;
                            in_ready  <= 1'b0;
                            op_q      <= ALUCtrl;
                            neg_q     <= sign_a ^ sign_b;
                            neg_rem_q <= sign_a;
                            dbz_q     <= (in2 == '0) &&
                                         ((ALUCtrl == OP_DIV) || (ALUCtrl == OP_REM));
                        end else begin
                            out       <= sc_result;
                            out_valid <= 1'b1;
                        end
                    end
                end
                // The final iteration's value is corrected and written so out_valid lands in DONE
                BUSY: begin
                    if (last) begin
                        state       <= DONE;
                        out         <= mc_result;
                        out_valid   <= 1'b1;
                        div_by_zero <= dbz_q;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign zero = (out == '0);

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu at WIDTH=32; expectations follow ALU_MDU_DIV_EN.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [4:0]   ALUCtrl = '0;
    logic         Sign = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out;
    logic         zero;
    logic         div_by_zero;
    state_t       state;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_dbz_q[$];

    alu_mdu #(.WIDTH(W), .SHAMT_LSB(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUCtrl     (ALUCtrl),
        .Sign        (Sign),
        .in1         (in1),
        .in2         (in2),
        .out_valid   (out_valid),
        .out         (out),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .state       (state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog expired");
    end

    // Reference model on 64-bit arithmetic
    function automatic logic [W-1:0] model(input logic [4:0] op, input logic sg,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           output logic dbz);
        logic [4:0] sh;
        longint     sa;
        longint     sb;
        longint     p;
        sh  = b[10:6];
        dbz = 1'b0;
        sa  = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sg ? longint'($signed(b)) : longint'({32'b0, b});
        case (op)
            OP_ADD:      return a + b;
            OP_SUB:      return a - b;
            OP_AND:      return a & b;
            OP_OR:       return a | b;
            OP_XOR:      return a ^ b;
            OP_NOR:      return ~(a | b);
            OP_SLL:      return a << sh;
            OP_SRL:      return a >> sh;
            OP_SRA:      return $signed(a) >>> sh;
            OP_SLT:      return {31'b0, (sa < sb)};
            OP_SHL_HALF: return a << 16;
            OP_MUL:      begin p = sa * sb; return p[31:0]; end
            OP_MULH:     begin p = sa * sb; return p[63:32]; end
`ifdef ALU_MDU_DIV_EN
            OP_DIV: begin
                if (b == '0) begin dbz = 1'b1; return '1; end
                p = sa / sb;
                return p[31:0];
            end
            OP_REM: begin
                if (b == '0) begin dbz = 1'b1; return a; end
                p = sa % sb;
                return p[31:0];
            end
`endif
            default: return '0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] op);
`ifdef ALU_MDU_DIV_EN
        return (op >= OP_MUL && op <= OP_REM) ? W + 1 : 1;
`else
        return (op == OP_MUL || op == OP_MULH) ? W + 1 : 1;
`endif
    endfunction

    // Driver tasks
    task automatic issue(input logic [4:0] op, input logic sg,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        ALUCtrl  = op;
        Sign     = sg;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Latency 1 means out_valid in the cycle right after the accepting edge
    task automatic wait_valid(input int budget, output int lat, output logic seen,
                              output logic ready_hi);
        lat = 1;
        seen = 1'b0;
        ready_hi = 1'b0;
        while (!seen && lat <= budget) begin
            if (in_ready) ready_hi = 1'b1;
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out !== '0) begin failures++; $display("FAIL reset_out: got %h expected 0", out); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero: got %b expected 1", zero); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected IDLE", state); end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [4:0]   t_op[4];
        logic         t_sg[4];
        logic [W-1:0] t_a[4];
        logic [W-1:0] t_b[4];
        logic [W-1:0] t_exp[4];
        logic [W-1:0] e;
        t_op  = '{OP_ADD, OP_SRA, OP_SLT, OP_SLT};
        t_sg  = '{1'b0, 1'b0, 1'b1, 1'b0};
        t_a   = '{32'h7FFF_FFFF, 32'hF000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_b   = '{32'h1, 32'h100, 32'h1, 32'h1};
        t_exp = '{32'h8000_0000, 32'hFF00_0000, 32'h1, 32'h0};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_%0d: got %b expected 1", i - 1, out_valid); end
                checks++; if (out !== e) begin failures++; $display("FAIL b2b_out_%0d: got %h expected %h", i - 1, out, e); end
            end
            if (i < 4) begin
                exp_q.push_back(t_exp[i]);
                ALUCtrl  = t_op[i];
                Sign     = t_sg[i];
                in1      = t_a[i];
                in2      = t_b[i];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_mul_div();
        logic [4:0]   t_op[9];
        logic         t_sg[9];
        logic [W-1:0] t_a[9];
        logic [W-1:0] t_b[9];
        logic [W-1:0] t_exp[9];
        logic         t_dbz[9];
        logic [W-1:0] e;
        logic         ed;
        int           lat;
        logic         seen;
        logic         rdy;
        t_op = '{OP_MUL, OP_MULH, OP_DIV, OP_REM, OP_DIV, OP_DIV, OP_DIV, OP_REM, OP_REM};
        t_sg = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t_a  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000,
                 32'h5, 32'h8000_0000, 32'h8000_0000, 32'h5};
        t_b  = '{32'h7, 32'h7, 32'h2, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'h0};
`ifdef ALU_MDU_DIV_EN
        t_exp = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0,
                  32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h5};
        t_dbz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        t_exp = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        t_dbz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(t_exp[i]);
            exp_dbz_q.push_back(t_dbz[i]);
            issue(t_op[i], t_sg[i], t_a[i], t_b[i]);
            wait_valid(60, lat, seen, rdy);
            e  = exp_q.pop_front();
            ed = exp_dbz_q.pop_front();
            checks++; if (!seen) begin failures++; $display("FAIL md_seen_%0d: got no out_valid expected a result", i); end
            checks++; if (out !== e) begin failures++; $display("FAIL md_out_%0d: got %h expected %h", i, out, e); end
            checks++; if (zero !== (e == '0)) begin failures++; $display("FAIL md_zero_%0d: got %b expected %b", i, zero, (e == '0)); end
            checks++; if (div_by_zero !== ed) begin failures++; $display("FAIL md_dbz_%0d: got %b expected %b", i, div_by_zero, ed); end
            checks++; if (lat != exp_lat(t_op[i])) begin failures++; $display("FAIL md_latency_%0d: got %0d expected %0d", i, lat, exp_lat(t_op[i])); end
            if (exp_lat(t_op[i]) > 1) begin
                checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL md_ready_busy_%0d: got in_ready high expected low", i); end
            end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL md_after_%0d: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset_busy();
        int           lat;
        logic         seen;
        logic         rdy;
        int           extra;
        logic [W-1:0] e;
        issue(OP_ADD, 1'b0, 32'h11, 32'h22);
        wait_valid(5, lat, seen, rdy);
        checks++; if (out !== 32'h33) begin failures++; $display("FAIL rb_pre_add: got %h expected 33", out); end
        issue(OP_MUL, 1'b0, 32'h1000, 32'h10);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (state !== BUSY) begin failures++; $display("FAIL rb_state_busy: got %0d expected BUSY", state); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rb_out_valid: got %b expected 0", out_valid); end
        checks++; if (out !== '0) begin failures++; $display("FAIL rb_out: got %h expected 0", out); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL rb_zero: got %b expected 1", zero); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rb_in_ready: got %b expected 1", in_ready); end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL rb_no_result: got %0d pulses expected 0", extra); end
        exp_q.push_back(32'h7);
        issue(OP_ADD, 1'b0, 32'h3, 32'h4);
        wait_valid(5, lat, seen, rdy);
        e = exp_q.pop_front();
        checks++; if (!seen || out !== e || lat != 1) begin
            failures++;
            $display("FAIL rb_post_add: got %h (seen=%b lat=%0d) expected %h lat 1", out, seen, lat, e);
        end
    endtask

    task automatic test_undefined();
        int           lat;
        logic         seen;
        logic         rdy;
        int           extra;
        logic [W-1:0] e;
        issue(OP_ADD, 1'b0, 32'h1, 32'h1);
        wait_valid(5, lat, seen, rdy);
        exp_q.push_back(32'h0);
        issue(5'd20, 1'b1, 32'h1234, 32'h5678);
        wait_valid(5, lat, seen, rdy);
        e = exp_q.pop_front();
        checks++; if (!seen || lat != 1) begin failures++; $display("FAIL undef_valid: got seen=%b lat=%0d expected lat 1", seen, lat); end
        checks++; if (out !== e) begin failures++; $display("FAIL undef_out: got %h expected %h", out, e); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL undef_zero: got %b expected 1", zero); end
        exp_q.push_back(32'd30);
        issue(OP_MUL, 1'b0, 32'd5, 32'd6);
        repeat (3) @(negedge clk);
        ALUCtrl  = OP_ADD;
        in1      = 32'h1;
        in2      = 32'h2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(60, lat, seen, rdy);
        e = exp_q.pop_front();
        checks++; if (!seen || out !== e) begin failures++; $display("FAIL drop_mul: got %h (seen=%b) expected %h", out, seen, e); end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL drop_extra: got %0d pulses expected 0", extra); end
    endtask

    task automatic test_random();
        logic [4:0]   op;
        logic         sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         d;
        logic [W-1:0] e;
        logic         ed;
        int           lat;
        logic         seen;
        logic         rdy;
        for (int i = 0; i < 24; i++) begin
            op = 5'($urandom_range(0, 31));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom();
            b  = ($urandom_range(0, 6) == 0) ? '0 : $urandom();
            exp_q.push_back(model(op, sg, a, b, d));
            exp_dbz_q.push_back(d);
            issue(op, sg, a, b);
            wait_valid(60, lat, seen, rdy);
            e  = exp_q.pop_front();
            ed = exp_dbz_q.pop_front();
            checks++; if (!seen || out !== e || div_by_zero !== ed || lat != exp_lat(op)) begin
                failures++;
                $display("FAIL rand_%0d op=%0d sg=%b a=%h b=%h: got %h dbz=%b lat=%0d expected %h dbz=%b lat=%0d",
                         i, op, sg, a, b, out, div_by_zero, lat, e, ed, exp_lat(op));
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul_div();
        test_reset_busy();
        test_undefined();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
